// File: rtl/warp_dispatcher_pkg.sv
// Shared types and constants for the warp dispatcher and the SIMD cores it feeds.
package warp_dispatcher_pkg;

  localparam int unsigned THREAD_COUNT = 4;
  localparam int unsigned MAX_WARPS    = 15;
  localparam logic [3:0]  NO_WARP_ID   = 4'hF;

  typedef struct packed {
    logic [3:0]  warp_id;
    logic [31:0] start_pc;
    logic [7:0]  thread_count;
  } kernel_t;

  localparam kernel_t KERNEL_IDLE = '{warp_id: NO_WARP_ID, start_pc: 32'h0, thread_count: 8'h0};

  typedef enum logic [1:0] {
    StIdle,
    StDispatch,
    StDrain,
    StDone
  } disp_state_e;

endpackage

// File: rtl/warp_dispatcher_if.sv
// Launch handshake, per-core kernel/finish signals and status of the warp dispatcher.
interface warp_dispatcher_if #(
  parameter int unsigned NUM_CORES = 2
);
  import warp_dispatcher_pkg::*;

  logic                      launch_valid;
  logic                      launch_ready;
  logic [31:0]               launch_pc;
  logic [7:0]                launch_threads;
  logic                      launch_error;
  kernel_t [NUM_CORES-1:0]   core_kernel;
  logic [NUM_CORES-1:0]      core_finished;
  logic [NUM_CORES-1:0][3:0] core_finished_warp_id;
  logic                      busy;
  logic                      kernel_done;
  logic [3:0]                warps_done;

  modport slave (
    input  launch_valid, launch_pc, launch_threads, core_finished, core_finished_warp_id,
    output launch_ready, launch_error, core_kernel, busy, kernel_done, warps_done
  );

  modport master (
    output launch_valid, launch_pc, launch_threads, core_finished, core_finished_warp_id,
    input  launch_ready, launch_error, core_kernel, busy, kernel_done, warps_done
  );

endinterface

// File: rtl/warp_dispatcher_core_slot_tracker.sv
// Per-core bookkeeping: busy flag, the kernel handed to the core and a post-dispatch blank counter.
module warp_dispatcher_core_slot_tracker
  import warp_dispatcher_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       assign_i,
  input  kernel_t    kernel_i,
  input  logic       check_en_i,
  input  logic       finished_i,
  input  logic [3:0] finished_warp_id_i,
  output logic       busy_o,
  output kernel_t    kernel_o,
  output logic       retire_o
);

  localparam logic [2:0] BlankInit = 3'(BLANK_CYCLES);

  logic       busy_q, busy_d;
  kernel_t    kernel_q, kernel_d;
  logic [2:0] blank_q, blank_d;

  // A stale finish from the previous occupant is filtered by both blanking and the id match.
  assign retire_o = check_en_i & busy_q & (blank_q == 3'd0) & finished_i &
                    (finished_warp_id_i == kernel_q.warp_id);

  always_comb begin
    busy_d   = busy_q;
    kernel_d = kernel_q;
    blank_d  = blank_q;
    if (blank_q != 3'd0) begin
      blank_d = blank_q - 3'd1;
    end
    if (retire_o) begin
      busy_d   = 1'b0;
      kernel_d = KERNEL_IDLE;
    end
    if (assign_i) begin
      busy_d   = 1'b1;
      kernel_d = kernel_i;
      blank_d  = BlankInit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      kernel_q <= KERNEL_IDLE;
      blank_q  <= 3'd0;
    end else begin
      busy_q   <= busy_d;
      kernel_q <= kernel_d;
      blank_q  <= blank_d;
    end
  end

  assign busy_o   = busy_q;
  assign kernel_o = kernel_q;

endmodule

// File: rtl/warp_dispatcher.sv
// Splits a kernel launch into warps, hands them to free SIMD cores and counts retirements.
module warp_dispatcher
  import warp_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 2,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  warp_dispatcher_if.slave bus
);

  disp_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  nwarps_q, nwarps_d;
  logic [7:0]  last_tc_q, last_tc_d;
  logic [3:0]  next_warp_q, next_warp_d;
  logic [3:0]  warps_done_q, warps_done_d;
  logic        launch_error_q, launch_error_d;
  logic        kernel_done_q, kernel_done_d;

  logic [NUM_CORES-1:0] slot_busy;
  logic [NUM_CORES-1:0] slot_retire;
  logic [NUM_CORES-1:0] slot_assign;
  logic [NUM_CORES-1:0] grant;
  logic                 free_found;
  logic                 check_en;
  kernel_t              dispatch_kernel;
  kernel_t [NUM_CORES-1:0] slot_kernel;

  // Launch geometry, evaluated combinationally on the incoming request.
  logic [8:0] threads_round;
  logic [7:0] nwarps_full;
  logic [7:0] rem;

  assign threads_round = {1'b0, bus.launch_threads} + 9'(THREAD_COUNT - 1);
  assign nwarps_full   = 8'(threads_round / 9'(THREAD_COUNT));
  assign rem           = bus.launch_threads % 8'(THREAD_COUNT);

  // Lowest-index free core wins.
  always_comb begin
    grant      = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!slot_busy[i] && !free_found) begin
        grant[i]   = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    dispatch_kernel.warp_id      = next_warp_q;
    dispatch_kernel.start_pc     = pc_q;
    dispatch_kernel.thread_count = (next_warp_q == nwarps_q - 4'd1) ? last_tc_q
                                                                    : 8'(THREAD_COUNT);
  end

  logic [4:0] retire_sum;
  logic [3:0] warps_done_inc;

  always_comb begin
    retire_sum = {1'b0, warps_done_q};
    for (int i = 0; i < NUM_CORES; i++) begin
      retire_sum = retire_sum + 5'(slot_retire[i]);
    end
    warps_done_inc = (retire_sum > 5'(MAX_WARPS)) ? 4'(MAX_WARPS) : retire_sum[3:0];
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    nwarps_d       = nwarps_q;
    last_tc_d      = last_tc_q;
    next_warp_d    = next_warp_q;
    warps_done_d   = warps_done_q;
    launch_error_d = 1'b0;
    kernel_done_d  = 1'b0;
    slot_assign    = '0;
    check_en       = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.launch_valid) begin
          pc_d         = bus.launch_pc;
          last_tc_d    = (rem == 8'd0) ? 8'(THREAD_COUNT) : rem;
          next_warp_d  = 4'd0;
          warps_done_d = 4'd0;
          if (bus.launch_threads == 8'd0) begin
            state_d = StDone;
          end else if (nwarps_full > 8'(MAX_WARPS)) begin
            launch_error_d = 1'b1;
          end else begin
            nwarps_d = nwarps_full[3:0];
            state_d  = StDispatch;
          end
        end
      end
      StDispatch: begin
        check_en = 1'b1;
        if (free_found) begin
          slot_assign = grant;
          next_warp_d = next_warp_q + 4'd1;
          if (next_warp_q == nwarps_q - 4'd1) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        check_en = 1'b1;
        if (warps_done_q == nwarps_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        kernel_done_d = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (check_en) begin
      warps_done_d = warps_done_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      pc_q           <= 32'h0;
      nwarps_q       <= 4'd0;
      last_tc_q      <= 8'd0;
      next_warp_q    <= 4'd0;
      warps_done_q   <= 4'd0;
      launch_error_q <= 1'b0;
      kernel_done_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      nwarps_q       <= nwarps_d;
      last_tc_q      <= last_tc_d;
      next_warp_q    <= next_warp_d;
      warps_done_q   <= warps_done_d;
      launch_error_q <= launch_error_d;
      kernel_done_q  <= kernel_done_d;
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
    warp_dispatcher_core_slot_tracker #(
      .BLANK_CYCLES(BLANK_CYCLES)
    ) u_slot (
      .clk               (clk),
      .rst               (rst),
      .assign_i          (slot_assign[i]),
      .kernel_i          (dispatch_kernel),
      .check_en_i        (check_en),
      .finished_i        (bus.core_finished[i]),
      .finished_warp_id_i(bus.core_finished_warp_id[i]),
      .busy_o            (slot_busy[i]),
      .kernel_o          (slot_kernel[i]),
      .retire_o          (slot_retire[i])
    );
  end

  assign bus.core_kernel  = slot_kernel;
  assign bus.launch_ready = (state_q == StIdle);
  assign bus.busy         = (state_q != StIdle);
  assign bus.launch_error = launch_error_q;
  assign bus.kernel_done  = kernel_done_q;
  assign bus.warps_done   = warps_done_q;

endmodule

// File: tb/tb_warp_dispatcher.sv
// Scoreboard bench: stimulus queues expected core_kernel / kernel_done / launch_error events with
// their cycle stamps; a monitor pops and compares whenever the dispatcher presents one.
module tb_warp_dispatcher;
  import warp_dispatcher_pkg::*;

  localparam int NCORES  = 2;
  localparam int EvKern  = 0;
  localparam int EvDone  = 1;
  localparam int EvErr   = 2;

  typedef struct {
    int         kind;
    int         core;
    kernel_t    kern;
    logic [3:0] wd;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  ev_t  exp_q[$];

  warp_dispatcher_if #(.NUM_CORES(NCORES)) bus ();

  warp_dispatcher #(
    .NUM_CORES   (NCORES),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic kernel_t mk(input logic [3:0] id, input logic [31:0] pc,
                                 input logic [7:0] tc);
    kernel_t k;
    k.warp_id      = id;
    k.start_pc     = pc;
    k.thread_count = tc;
    return k;
  endfunction

  task automatic push_kern(input int core, input kernel_t k, input int at);
    exp_q.push_back('{kind: EvKern, core: core, kern: k, wd: 4'h0, cyc: at});
  endtask

  task automatic push_done(input logic [3:0] wd, input int at);
    exp_q.push_back('{kind: EvDone, core: -1, kern: KERNEL_IDLE, wd: wd, cyc: at});
  endtask

  task automatic push_err(input int at);
    exp_q.push_back('{kind: EvErr, core: -1, kern: KERNEL_IDLE, wd: 4'h0, cyc: at});
  endtask

  task automatic sb_check(input ev_t o);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_unexpected: got kind=%0d core=%0d kern=%h wd=%0d cyc=%0d, want no event",
               o.kind, o.core, o.kern, o.wd, o.cyc);
    end else begin
      e = exp_q.pop_front();
      if (o.kind != e.kind || o.core != e.core || o.kern !== e.kern || o.wd !== e.wd ||
          o.cyc != e.cyc) begin
        n_err++;
        $display("FAIL sb_event: got kind=%0d core=%0d kern=%h wd=%0d cyc=%0d, want kind=%0d core=%0d kern=%h wd=%0d cyc=%0d",
                 o.kind, o.core, o.kern, o.wd, o.cyc, e.kind, e.core, e.kern, e.wd, e.cyc);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sb(input string name);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d pending events, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: any change on a core_kernel, or a done/error pulse, is an event to match.
  initial begin
    kernel_t prev[NCORES];
    wait (mon_en);
    for (int i = 0; i < NCORES; i++) prev[i] = bus.core_kernel[i];
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCORES; i++) begin
        if (bus.core_kernel[i] !== prev[i]) begin
          sb_check('{kind: EvKern, core: i, kern: bus.core_kernel[i], wd: 4'h0, cyc: cyc});
          prev[i] = bus.core_kernel[i];
        end
      end
      if (bus.kernel_done !== 1'b0)
        sb_check('{kind: EvDone, core: -1, kern: KERNEL_IDLE, wd: bus.warps_done, cyc: cyc});
      if (bus.launch_error !== 1'b0)
        sb_check('{kind: EvErr, core: -1, kern: KERNEL_IDLE, wd: 4'h0, cyc: cyc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    int a;
    bus.launch_valid          = 1'b0;
    bus.launch_pc             = 32'h0;
    bus.launch_threads        = 8'd0;
    bus.core_finished         = '0;
    bus.core_finished_warp_id = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_ready", 64'(bus.launch_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_warps_done", 64'(bus.warps_done), 64'd0);
    chk("rst_kernel_done", 64'(bus.kernel_done), 64'd0);
    chk("rst_launch_error", 64'(bus.launch_error), 64'd0);
    for (int i = 0; i < NCORES; i++) chk("rst_core_kernel", 64'(bus.core_kernel[i]),
                                         64'(KERNEL_IDLE));
    mon_en = 1'b1;
    tick();

    // 10 threads -> warps of 4, 4, 2.
    a = cyc;
    bus.launch_valid   = 1'b1;
    bus.launch_pc      = 32'h100;
    bus.launch_threads = 8'd10;
    push_kern(0, mk(4'd0, 32'h100, 8'd4), a + 2);
    push_kern(1, mk(4'd1, 32'h100, 8'd4), a + 3);
    tick();
    bus.launch_valid = 1'b0;
    chk("l1_ready_low", 64'(bus.launch_ready), 64'd0);
    chk("l1_busy", 64'(bus.busy), 64'd1);
    tick();
    bus.core_finished[0]         = 1'b1;
    bus.core_finished_warp_id[0] = 4'd0;
    tick();
    tick();
    bus.core_finished_warp_id[0] = 4'h7;
    tick();
    chk("spurious_ignored", 64'(bus.warps_done), 64'd0);
    bus.core_finished_warp_id[0] = 4'd0;
    push_kern(0, KERNEL_IDLE, a + 6);
    push_kern(0, mk(4'd2, 32'h100, 8'd2), a + 7);
    tick();
    bus.core_finished = '0;
    chk("l1_one_retired", 64'(bus.warps_done), 64'd1);
    repeat (3) tick();
    bus.core_finished            = 2'b11;
    bus.core_finished_warp_id[0] = 4'd2;
    bus.core_finished_warp_id[1] = 4'd1;
    push_kern(0, KERNEL_IDLE, a + 10);
    push_kern(1, KERNEL_IDLE, a + 10);
    push_done(4'd3, a + 12);
    tick();
    bus.core_finished = '0;
    chk("dual_retire", 64'(bus.warps_done), 64'd3);
    wait_sb("launch10");
    tick();
    chk("hold_warps_done", 64'(bus.warps_done), 64'd3);

    // Zero-thread launch: straight to DONE.
    a = cyc;
    bus.launch_valid   = 1'b1;
    bus.launch_threads = 8'd0;
    push_done(4'd0, a + 2);
    tick();
    bus.launch_valid = 1'b0;
    chk("zero_cleared", 64'(bus.warps_done), 64'd0);
    wait_sb("launch0");
    tick();

    // 61 threads -> 16 warps, rejected.
    a = cyc;
    bus.launch_valid   = 1'b1;
    bus.launch_pc      = 32'h400;
    bus.launch_threads = 8'd61;
    push_err(a + 1);
    tick();
    bus.launch_valid = 1'b0;
    chk("err_ready", 64'(bus.launch_ready), 64'd1);
    chk("err_busy", 64'(bus.busy), 64'd0);
    tick();
    chk("err_ready_after", 64'(bus.launch_ready), 64'd1);
    wait_sb("launch61");
    tick();

    // 8 threads, retire one warp, then reset while draining.
    a = cyc;
    bus.launch_valid   = 1'b1;
    bus.launch_pc      = 32'h2000;
    bus.launch_threads = 8'd8;
    push_kern(0, mk(4'd0, 32'h2000, 8'd4), a + 2);
    push_kern(1, mk(4'd1, 32'h2000, 8'd4), a + 3);
    tick();
    bus.launch_valid = 1'b0;
    repeat (3) tick();
    bus.core_finished[0]         = 1'b1;
    bus.core_finished_warp_id[0] = 4'd0;
    push_kern(0, KERNEL_IDLE, a + 5);
    tick();
    bus.core_finished = '0;
    chk("drain_warps_done", 64'(bus.warps_done), 64'd1);
    chk("drain_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    push_kern(1, KERNEL_IDLE, a + 5);
    #1;
    chk("mid_rst_ready", 64'(bus.launch_ready), 64'd1);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_warps_done", 64'(bus.warps_done), 64'd0);
    chk("mid_rst_kernel1", 64'(bus.core_kernel[1]), 64'(KERNEL_IDLE));
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_done_low", 64'(bus.kernel_done), 64'd0);
    wait_sb("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/warp_dispatcher.md
Name: warp_dispatcher

Overview:
- Upstream of the SIMD cores. Accepts one kernel launch at a time as a start PC plus a total thread count.
- Splits the launch into warps of THREAD_COUNT threads and drives one kernel_t per core into the cores' kernel_in ports.
- Tracks each core's is_finished_out / finished_warp_id to free cores and count completed warps.
- Pulses kernel_done when every warp of the launch has retired.

Parameters:
- THREAD_COUNT, 4, threads per warp; must equal the simd_core setting (shared package constant).
- NUM_CORES, 2, number of simd_core instances driven; 1..8.
- BLANK_CYCLES, 2, cycles after dispatch during which a core's finished indication is ignored; 1..7.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- launch_valid  in  1  launch request
- launch_ready  out  1  dispatcher accepts a launch
- launch_pc  in  32  start PC shared by all warps
- launch_threads  in  8  total threads in the launch
- launch_error  out  1  one-cycle pulse: launch rejected
- core_kernel  out  kernel_t[NUM_CORES]  to each core's kernel_in
- core_finished  in  NUM_CORES  each core's is_finished_out
- core_finished_warp_id  in  4[NUM_CORES]  each core's finished_warp_id
- busy  out  1  launch in progress
- kernel_done  out  1  one-cycle pulse: all warps retired
- warps_done  out  4  warps retired in the current or last launch

Behaviour:
- Reset values:
  - launch_ready=1; busy=0; kernel_done=0; launch_error=0; warps_done=0.
  - Every core_kernel = {warp_id=4'hF, start_pc=0, thread_count=0}.
  - All cores marked free; FSM in IDLE.
- kernel_t fields: warp_id[3:0], start_pc[31:0], thread_count[7:0]. warp_id 4'hF is reserved to mean "no warp".
- Launch geometry:
  - nwarps = ceil(launch_threads / THREAD_COUNT).
  - Warp k gets warp_id=k and start_pc=launch_pc.
  - thread_count = THREAD_COUNT for every warp except the last, which gets the remainder (or THREAD_COUNT if the division is exact).
- States:
  - IDLE:
    - launch_ready=1. A launch is accepted when launch_valid & launch_ready; the launch fields are latched and warps_done is cleared.
    - launch_threads=0 -> DONE next cycle with no dispatch.
    - nwarps>15 -> launch_error pulses the next cycle and the FSM stays in IDLE.
    - Otherwise -> DISPATCH.
  - DISPATCH:
    - At most one warp issued per cycle, to the lowest-index free core.
    - That core's core_kernel is loaded and held stable until the core frees. The core is marked busy and its blank counter is loaded with BLANK_CYCLES.
    - After the last warp is issued -> DRAIN.
    - No free core -> wait without issuing.
  - DRAIN: when warps_done == nwarps -> DONE.
  - DONE: kernel_done=1 for exactly one cycle -> IDLE.
  - launch_ready=0 and busy=1 in every state except IDLE.
- Completion detection, per core, evaluated every cycle in DISPATCH and DRAIN. A core retires its warp when all of the following hold:
  - it is busy;
  - its blank counter is 0;
  - core_finished[i]=1;
  - core_finished_warp_id[i] equals its assigned warp_id.
- On retirement:
  - The core becomes free and its core_kernel returns to the idle value on the next cycle.
  - warps_done increments.
  - The freed core is not eligible for dispatch in the same cycle it retires; it is eligible the cycle after.
- Multiple cores may retire in the same cycle: warps_done increments by the popcount of retiring cores (4-bit saturating, cannot exceed 15).
- A finished indication with a mismatched warp_id, or during blanking, is ignored. The counter simply continues.
- Blank counters decrement to 0 and stop there.
- Retirement and dispatch in the same cycle (different cores) are both performed.
- warps_done holds its final value after DONE until the next accepted launch.
- launch_valid while not ready is ignored; no queueing.
- rst asserted mid-launch: all state returns to reset values immediately. In-flight warps are abandoned and no kernel_done is produced.

Decomposition:
- Shared package (Structs_and_Params.svh): kernel_t, THREAD_COUNT, NO_WARP_ID=4'hF, dispatcher FSM state enum.
- One natural sub-module: core_slot_tracker, one instance per core.
  - Holds busy flag, assigned kernel_t and blank counter.
  - Takes an assign strobe and produces a retire strobe.
- The top level contains the FSM, the warp splitter arithmetic and the free-core priority encoder.

Test Plan:
- Reset -> launch_ready=1; all core_kernel.warp_id=4'hF; busy=0; warps_done=0.
- launch_pc=0x100, launch_threads=10, NUM_CORES=2:
  - warp0 (tc=4) goes to core0 and warp1 (tc=4) to core1 on consecutive cycles.
  - Finish core0 with id 0 after blanking -> warp2 (tc=2) lands on core0 exactly one cycle after retirement.
  - Finish all warps -> kernel_done single pulse, warps_done=3.
- launch_threads=0 -> no core_kernel change; kernel_done pulses 2 cycles after accept; warps_done=0.
- launch_threads=61 (16 warps) -> launch_error single pulse; no dispatch; launch_ready returns to 1.
- Spurious finishes:
  - core_finished=1 during blanking, and core_finished with warp_id 4'h7 while core0 holds warp 0 -> no retirement.
  - The correct id after blanking -> retirement.
- Both cores retire in the same cycle -> warps_done +2.
- rst asserted mid-DRAIN -> all outputs return to reset values; no kernel_done pulse.
